alu_result_checker: RTL

- Hardware response checker for the 4-bit ALU. It is the consuming end of the A/B/op -> out/cout/overflow/zero interface.
- Accepts observed ALU transactions (operands, opcode, ALU outputs) over a valid/ready handshake.
- Recomputes the golden result internally and counts checks and mismatches. Captures the first failing vector.
- Sits beside the ALU in self-test builds; a stimulus sequencer drives the ALU and feeds this block.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_ref_model.sv | 54 +++++
 rtl/alu_result_checker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its result checker: opcodes,
// checker FSM encoding and the layout of the captured first failing vector.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [OP_W-1:0] ALU_NOT = 3'b101;
  localparam logic [OP_W-1:0] ALU_SHL = 3'b110;
  localparam logic [OP_W-1:0] ALU_SHR = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RUN   = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_FAIL  = 3'd4;

  localparam int FE_W = 23;

  // Bit 22 is a spare kept at zero so the word stays 23 bits wide.
  typedef struct packed {
    logic              pad;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] obs_out;
    logic              obs_cout;
    logic              obs_overflow;
    logic              obs_zero;
    logic [DATA_W-1:0] exp_out;
  } first_err_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU: (a, b, op) -> expected
// result and flags. Usable standalone by other benches.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] exp_out,
  output logic              exp_cout,
  output logic              exp_overflow,
  output logic              exp_zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1, so the carry out reads as "no borrow".
  assign diff = {1'b0, a} + {1'b0, ~b} + 5'd1;

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    exp_out      = '0;
    exp_cout     = 1'b0;
    exp_overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        {exp_cout, exp_out} = sum;
        exp_overflow = (a[3] == b[3]) && (sum[3] != a[3]);
      end
      ALU_SUB: begin
        {exp_cout, exp_out} = diff;
        exp_overflow = (a[3] != b[3]) && (diff[3] != a[3]);
      end
      ALU_AND: exp_out = a & b;
      ALU_OR:  exp_out = a | b;
      ALU_XOR: exp_out = a ^ b;
      ALU_NOT: exp_out = ~a;
      ALU_SHL: begin
        exp_out  = {a[2:0], 1'b0};
        exp_cout = a[3];
      end
      ALU_SHR: begin
        exp_out  = {1'b0, a[3:1]};
        exp_cout = a[0];
      end
      default: exp_out = '0;
    endcase
  end

  assign exp_zero = (exp_out == '0);

endmodule

// File: rtl/alu_result_checker.sv
// Consuming-end checker for the 4-bit ALU: recomputes each observed result,
// counts checks and mismatches, captures the first failing vector.
// Define ALU_CHK_FLAGS_EN to compare cout/overflow/zero as well as out.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int NUM_VEC     = 16,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              obs_valid,
  output logic              obs_ready,
  input  logic [DATA_W-1:0] obs_A,
  input  logic [DATA_W-1:0] obs_B,
  input  logic [OP_W-1:0]   obs_op,
  input  logic [DATA_W-1:0] obs_out,
  input  logic              obs_cout,
  input  logic              obs_overflow,
  input  logic              obs_zero,
  output logic [CNT_W-1:0]  check_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              done,
  output logic              fail,
  output logic [FE_W-1:0]   first_err
);

  localparam logic [15:0] NUM_VEC_L = 16'(NUM_VEC);
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VEC - 1);

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       acc_cnt;
  logic              s1_valid;
  first_err_t        s1_vec;

  logic [DATA_W-1:0] exp_out;
  logic              exp_cout;
  logic              exp_overflow;
  logic              exp_zero;

  logic              xfer;
  logic              start_run;
  logic              vec_diff;
  logic              mismatch;
  logic              halt;
  logic [CNT_W-1:0]  chk_nxt;
  logic [CNT_W-1:0]  err_nxt;

  alu_ref_model u_ref (
    .a            (obs_A),
    .b            (obs_B),
    .op           (obs_op),
    .exp_out      (exp_out),
    .exp_cout     (exp_cout),
    .exp_overflow (exp_overflow),
    .exp_zero     (exp_zero)
  );

  assign obs_ready = (state == ST_RUN) && (acc_cnt < NUM_VEC_L);
  assign xfer      = obs_valid && obs_ready;
  assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));

  // NOTE: datapath registers carry no reset; s1_valid qualifies every use.
  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_vec <= '{pad:          1'b0,
                  a:            obs_A,
                  b:            obs_B,
                  op:           obs_op,
                  obs_out:      obs_out,
                  obs_cout:     obs_cout,
                  obs_overflow: obs_overflow,
                  obs_zero:     obs_zero,
                  exp_out:      exp_out};
    end
  end

`ifdef ALU_CHK_FLAGS_EN
  logic s1_exp_cout;
  logic s1_exp_overflow;
  logic s1_exp_zero;

  always_ff @(posedge clk) begin
    if (xfer) begin
      s1_exp_cout     <= exp_cout;
      s1_exp_overflow <= exp_overflow;
      s1_exp_zero     <= exp_zero;
    end
  end

  assign vec_diff = (s1_vec.obs_out      != s1_vec.exp_out)  ||
                    (s1_vec.obs_cout     != s1_exp_cout)     ||
                    (s1_vec.obs_overflow != s1_exp_overflow) ||
                    (s1_vec.obs_zero     != s1_exp_zero);
`else
  logic unused_exp_flags;

  assign unused_exp_flags = ^{exp_cout, exp_overflow, exp_zero};
  assign vec_diff         = (s1_vec.obs_out != s1_vec.exp_out);
`endif

  assign mismatch = s1_valid && vec_diff;
  assign halt     = (HALT_ON_ERR != 0) && mismatch;

  // Counters stick at all-ones rather than wrapping back to zero.
  assign chk_nxt = (s1_valid && (check_cnt != '1)) ? check_cnt + CNT_W'(1) : check_cnt;
  assign err_nxt = (mismatch && (err_cnt != '1))   ? err_cnt + CNT_W'(1)   : err_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start_run) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt)                             state_nxt = ST_FAIL;
        else if (xfer && (acc_cnt == LAST_IDX)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last vector's compare lands on this edge; err_nxt includes it.
        state_nxt = (err_nxt != '0) ? ST_FAIL : ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc_cnt   <= '0;
      s1_valid  <= 1'b0;
      check_cnt <= '0;
      err_cnt   <= '0;
      first_err <= '0;
    end else begin
      state <= state_nxt;
      if (start_run) begin
        acc_cnt   <= '0;
        s1_valid  <= 1'b0;
        check_cnt <= '0;
        err_cnt   <= '0;
        first_err <= '0;
      end else begin
        // A vector accepted on the halting edge is dropped, never compared.
        s1_valid  <= xfer && !halt;
        check_cnt <= chk_nxt;
        err_cnt   <= err_nxt;
        if (xfer) acc_cnt <= acc_cnt + 16'd1;
        if (mismatch && (err_cnt == '0)) first_err <= s1_vec;
      end
    end
  end

  assign done = (state == ST_DONE);
  assign fail = (state == ST_FAIL);

endmodule
